// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter giving three requesters turns on one shared I2C master.
// Each transaction runs START -> WAIT (timeout guarded) -> GAP before re-arbitration.
module i2c_bus_arbiter #(
  parameter logic [31:0] TIMEOUT    = 32'd100000,
  parameter logic [7:0]  GAP_CYCLES = 8'd125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  req_rw,
  input  logic [20:0] req_chip,
  input  logic [23:0] req_addr,
  input  logic [23:0] req_wdata,
  output logic [2:0]  gnt,
  output logic [2:0]  ack,
  output logic [2:0]  err,
  output logic [7:0]  rdata,
  output logic        m_start,
  output logic        m_rw,
  output logic [6:0]  m_chip,
  output logic [7:0]  m_addr,
  output logic [7:0]  m_wdata,
  input  logic        m_done,
  input  logic        m_nack,
  input  logic [7:0]  m_rdata,
  output logic        busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] GAP   = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  r_ptr;
  logic [2:0]  r_gnt;
  logic [2:0]  r_ack;
  logic [2:0]  r_err;
  logic [7:0]  r_rdata;
  logic        r_m_start;
  logic        r_m_rw;
  logic [6:0]  r_m_chip;
  logic [7:0]  r_m_addr;
  logic [7:0]  r_m_wdata;
  logic [31:0] r_wait_cnt;
  logic [7:0]  r_gap_cnt;

  logic [6:0]  w_chip  [3];
  logic [7:0]  w_addr  [3];
  logic [7:0]  w_wdata [3];
  logic [1:0]  w_order [3];
  logic [1:0]  w_win;
  logic [2:0]  w_win_oh;
  logic [1:0]  w_next_ptr;
  logic        w_timeout;
  logic        w_gap_done;

  // w_order[k] is the requester index examined k-th, starting from the pointer.
  for (genvar gi = 0; gi < 3; gi++) begin : g_req
    logic [2:0] w_sum;
    assign w_chip[gi]  = req_chip[7*gi +: 7];
    assign w_addr[gi]  = req_addr[8*gi +: 8];
    assign w_wdata[gi] = req_wdata[8*gi +: 8];
    assign w_sum       = {1'b0, r_ptr} + 3'(gi);
    assign w_order[gi] = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
  end

  always_comb begin
    w_win = w_order[2];
    if (req[w_order[0]])      w_win = w_order[0];
    else if (req[w_order[1]]) w_win = w_order[1];
  end

  assign w_win_oh   = 3'b001 << w_win;
  assign w_next_ptr = (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;
  assign w_timeout  = (r_wait_cnt == TIMEOUT - 32'd1);
  // A zero gap still spends one cycle in GAP so gnt is seen low before IDLE.
  assign w_gap_done = (GAP_CYCLES == 8'd0) || (r_gap_cnt == GAP_CYCLES - 8'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ptr      <= 2'd0;
      r_gnt      <= 3'b000;
      r_ack      <= 3'b000;
      r_err      <= 3'b000;
      r_rdata    <= 8'h00;
      r_m_start  <= 1'b0;
      r_m_rw     <= 1'b0;
      r_m_chip   <= 7'h00;
      r_m_addr   <= 8'h00;
      r_m_wdata  <= 8'h00;
      r_wait_cnt <= 32'd0;
      r_gap_cnt  <= 8'd0;
    end else begin
      r_ack     <= 3'b000;
      r_err     <= 3'b000;
      r_m_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|req) begin
            r_state   <= START;
            r_gnt     <= w_win_oh;
            r_ptr     <= w_next_ptr;
            r_m_rw    <= req_rw[w_win];
            r_m_chip  <= w_chip[w_win];
            r_m_addr  <= w_addr[w_win];
            r_m_wdata <= w_wdata[w_win];
            r_m_start <= 1'b1;
          end
        end
        START: begin
          r_state    <= WAIT;
          r_wait_cnt <= 32'd0;
        end
        WAIT: begin
          if (m_done) begin
            r_ack     <= r_gnt;
            r_err     <= m_nack ? r_gnt : 3'b000;
            if (r_m_rw && !m_nack) r_rdata <= m_rdata;
            r_gnt     <= 3'b000;
            r_gap_cnt <= 8'd0;
            r_state   <= GAP;
          end else if (w_timeout) begin
            r_ack     <= r_gnt;
            r_err     <= r_gnt;
            r_gnt     <= 3'b000;
            r_gap_cnt <= 8'd0;
            r_state   <= GAP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 32'd1;
          end
        end
        GAP: begin
          if (w_gap_done) r_state   <= IDLE;
          else            r_gap_cnt <= r_gap_cnt + 8'd1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign ack     = r_ack;
  assign err     = r_err;
  assign rdata   = r_rdata;
  assign m_start = r_m_start;
  assign m_rw    = r_m_rw;
  assign m_chip  = r_m_chip;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: grant order, read/NACK/timeout completion, reset abort.
// Runs with TIMEOUT = 50 and GAP_CYCLES = 4.
module tb_i2c_bus_arbiter;
  localparam logic [31:0] TO  = 32'd50;
  localparam logic [7:0]  GAP = 8'd4;

  logic        clk;
  logic        reset;
  logic [2:0]  req, req_rw, gnt, ack, err;
  logic [20:0] req_chip;
  logic [23:0] req_addr, req_wdata;
  logic [7:0]  rdata, m_addr, m_wdata, m_rdata;
  logic [6:0]  m_chip;
  logic        m_start, m_rw, m_done, m_nack, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int grant_cyc = 0;
  int prev_cyc  = 0;
  int n;

  i2c_bus_arbiter #(.TIMEOUT(TO), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_chip(req_chip),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .ack(ack), .err(err),
    .rdata(rdata), .m_start(m_start), .m_rw(m_rw), .m_chip(m_chip), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h required %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Wait for a grant, then complete it with m_done after dly WAIT cycles.
  task automatic txn(input string tag, input logic [2:0] exp_gnt, input logic [6:0] exp_chip,
                     input int dly, input logic nack, input logic [7:0] rd, input logic drop);
    int k;
    k = 0;
    while (gnt === 3'b000 && k < 40) begin
      tick();
      k++;
    end
    grant_cyc = cyc;
    check({tag, " gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, " m_start"}, 32'(m_start), 32'd1);
    check({tag, " m_chip"}, 32'(m_chip), 32'(exp_chip));
    if (drop) req = 3'b000;
    tick();
    check({tag, " m_start low"}, 32'(m_start), 32'd0);
    repeat (dly) tick();
    m_done  = 1'b1;
    m_nack  = nack;
    m_rdata = rd;
    tick();
    m_done  = 1'b0;
    m_nack  = 1'b0;
    m_rdata = 8'h00;
    check({tag, " ack"}, 32'(ack), 32'(exp_gnt));
    check({tag, " err"}, 32'(err), nack ? 32'(exp_gnt) : 32'd0);
    check({tag, " gnt cleared"}, 32'(gnt), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    req       = 3'b000;
    req_rw    = 3'b000;
    req_chip  = {7'h52, 7'h21, 7'h39};
    req_addr  = {8'hC0, 8'h42, 8'h98};
    req_wdata = {8'hE2, 8'h11, 8'h03};
    m_done    = 1'b0;
    m_nack    = 1'b0;
    m_rdata   = 8'h00;
    repeat (3) tick();
    check("rst gnt", 32'(gnt), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst m_start", 32'(m_start), 32'd0);
    check("rst rdata", 32'(rdata), 32'd0);
    reset = 1'b0;

    // Single write by requester 0
    req = 3'b001;
    txn("wr0", 3'b001, 7'h39, 8, 1'b0, 8'h00, 1'b0);
    check("wr0 m_addr", 32'(m_addr), 32'h98);
    check("wr0 m_wdata", 32'(m_wdata), 32'h03);
    check("wr0 busy in gap", 32'(busy), 32'd1);
    req = 3'b000;
    repeat (3) tick();
    check("wr0 gap busy", 32'(busy), 32'd1);
    tick();
    check("wr0 idle", 32'(busy), 32'd0);

    // Round-robin with all requesting, from a freshly reset pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 3'b111;
    txn("rr1", 3'b001, 7'h39, 2, 1'b0, 8'h00, 1'b0);
    prev_cyc = grant_cyc;
    txn("rr2", 3'b010, 7'h21, 2, 1'b0, 8'h00, 1'b0);
    check("rr2 spacing", 32'(grant_cyc - prev_cyc >= 6), 32'd1);
    prev_cyc = grant_cyc;
    txn("rr3", 3'b100, 7'h52, 2, 1'b0, 8'h00, 1'b0);
    check("rr3 spacing", 32'(grant_cyc - prev_cyc >= 6), 32'd1);
    prev_cyc = grant_cyc;
    txn("rr4", 3'b001, 7'h39, 2, 1'b0, 8'h00, 1'b0);
    check("rr4 spacing", 32'(grant_cyc - prev_cyc >= 6), 32'd1);
    req = 3'b000;
    repeat (5) tick();

    // Read by requester 1, request dropped mid-transaction
    req    = 3'b010;
    req_rw = 3'b010;
    txn("rd1", 3'b010, 7'h21, 3, 1'b0, 8'h5A, 1'b1);
    check("rd1 rdata", 32'(rdata), 32'h5A);
    check("rd1 m_addr", 32'(m_addr), 32'h42);
    check("rd1 m_rw", 32'(m_rw), 32'd1);
    req_rw = 3'b000;
    repeat (5) tick();

    // NACKed write by requester 2
    req = 3'b100;
    txn("nack2", 3'b100, 7'h52, 1, 1'b1, 8'hEE, 1'b1);
    check("nack2 rdata held", 32'(rdata), 32'h5A);
    repeat (5) tick();

    // Timeout with no m_done
    req = 3'b001;
    n = 0;
    while (gnt === 3'b000 && n < 40) begin
      tick();
      n++;
    end
    check("to gnt", 32'(gnt), 32'd1);
    req = 3'b000;
    tick();
    n = 0;
    while (ack === 3'b000 && n < 100) begin
      tick();
      n++;
    end
    check("to cycles", 32'(n), 32'd50);
    check("to ack", 32'(ack), 32'd1);
    check("to err", 32'(err), 32'd1);
    check("to rdata held", 32'(rdata), 32'h5A);
    tick();
    check("to ack pulse", 32'(ack), 32'd0);
    repeat (2) tick();
    check("to gap busy", 32'(busy), 32'd1);
    tick();
    check("to idle", 32'(busy), 32'd0);

    // m_done on the same edge as the timeout: completion wins
    req = 3'b001;
    txn("collide", 3'b001, 7'h39, 49, 1'b0, 8'h77, 1'b1);
    repeat (5) tick();

    // m_done while idle
    m_done  = 1'b1;
    m_nack  = 1'b1;
    m_rdata = 8'hAA;
    tick();
    m_done  = 1'b0;
    m_nack  = 1'b0;
    m_rdata = 8'h00;
    check("idle done ack", 32'(ack), 32'd0);
    check("idle done busy", 32'(busy), 32'd0);
    check("idle done rdata", 32'(rdata), 32'h5A);

    // Reset three cycles into WAIT; requester 1 grant leaves pointer at 2
    req = 3'b010;
    tick();
    check("ab gnt", 32'(gnt), 32'h2);
    tick();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("ab gnt", 32'(gnt), 32'd0);
    check("ab ack", 32'(ack), 32'd0);
    check("ab err", 32'(err), 32'd0);
    check("ab busy", 32'(busy), 32'd0);
    check("ab m_chip", 32'(m_chip), 32'd0);
    check("ab rdata", 32'(rdata), 32'd0);
    reset = 1'b0;
    req = 3'b101;
    txn("post0", 3'b001, 7'h39, 1, 1'b0, 8'h00, 1'b1);
    repeat (5) tick();
    req = 3'b100;
    txn("post2", 3'b100, 7'h52, 1, 1'b0, 8'h00, 1'b1);
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
